adder_arbiter: RTL
==================

Name: adder_arbiter

Overview:
- Shares one WIDTH-bit two's-complement adder between NREQ requesters using round-robin arbitration.
- Each requester presents REQ and operands, then receives a one-hot GNT acknowledge and a DONE pulse with a registered SUM, carry and signed overflow.
- Sits between client blocks and the shared adder datapath, and sequences capture, add and result delivery.

Parameters:
WIDTH  64  operand/result width in bits
NREQ   4   number of requesters (2..8)
PTRW   2   width of the round-robin pointer, equal to clog2(NREQ)

Ports:
CLK   input   1           rising-edge clock
RST   input   1           synchronous, active-high reset
REQ   input   NREQ        per-requester request, level
A_IN  input   NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
B_IN  input   NREQ*WIDTH  operand B; same packing as A_IN
GNT   output  NREQ        one-hot grant, registered, asserted for one cycle
DONE  output  NREQ        one-hot result-valid pulse, registered, asserted for one cycle
SUM   output  WIDTH       registered A+B mod 2^WIDTH
COUT  output  1           unsigned carry out of bit WIDTH-1
OVF   output  1           signed overflow
BUSY  output  1           high when state is not IDLE

Behaviour:
- Clock and reset:
  - Single clock CLK; RST is synchronous and active-high, sampled on the CLK rising edge.
  - Reset values: state=IDLE, pointer=0, GNT=0, DONE=0, SUM=0, COUT=0, OVF=0, BUSY=0, operand registers=0.
- State IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise, the winner is the first i with REQ[i]=1, searching pointer, pointer+1, ... modulo NREQ.
  - On that edge: latch A_IN/B_IN slices of the winner into operand registers, set GNT[winner]=1, store winner index, pointer <= (winner+1) mod NREQ, go to ADD.
- State ADD (one cycle, GNT high):
  - On the edge: {COUT,SUM} <= A_r + B_r at WIDTH+1 bits.
  - OVF <= (A_r[MSB]==B_r[MSB]) && (result[MSB]!=A_r[MSB]).
  - GNT <= 0, DONE[winner] <= 1, go to DONE.
- State DONE (one cycle, DONE high, SUM/COUT/OVF valid):
  - On the edge: DONE <= 0, go to IDLE.
  - REQ is not sampled in this state.
- Latency and throughput:
  - REQ high in IDLE at cycle k gives GNT in cycle k+1, DONE and result in k+2, and IDLE in k+3.
  - Peak throughput is one operation per 3 cycles.
- Hold behaviour: SUM/COUT/OVF hold their values until the next ADD edge. They are not cleared when DONE falls.
- Requester protocol:
  - Hold operands stable while REQ is high and GNT has not yet been seen.
  - Deassert REQ on the edge where GNT is seen.
  - A REQ still high when the FSM returns to IDLE is treated as a new request.
- Operand capture: operands are captured at the grant edge. A REQ or operand change after that edge does not affect the in-flight operation.
- Fairness: requests arriving during ADD/DONE wait in line and are arbitrated only in IDLE. No requester waits more than NREQ operations.
- Reset mid-operation: any state returns to IDLE next cycle. The in-flight result is discarded, no DONE is issued, the pointer returns to 0 and outputs take their reset values.
- Invariants: GNT and DONE are never both nonzero, and never have more than one bit set.
- Arithmetic and pointer wrap: arithmetic is modulo 2^WIDTH, and WIDTH+1 bits are used internally for COUT. The pointer wraps from NREQ-1 to 0.

Test Plan:
1. Reset, then REQ[0]=1 with A=64'h7FFFFFFFFFFFFFFF, B=64'h7FFFFFFFFFFFFFFF -> GNT=4'b0001 at k+1; DONE=4'b0001 at k+2 with SUM=64'hFFFFFFFFFFFFFFFE, COUT=0, OVF=1.
2. REQ[2]=1, A=64'hFFFFFFFFFFFFFFFF, B=64'h1 -> SUM=64'h0, COUT=1, OVF=0, DONE=4'b0100. SUM holds 0 while idle afterwards.
3. REQ=4'b1111 held, each requester drops REQ after its GNT and re-raises it after its DONE -> grant order 0,1,2,3,0,1; BUSY low exactly one cycle between operations.
4. Starting from pointer 0, REQ=4'b1010 -> grant 1 then 3. Then, with only REQ[1] high, requester 1 is granted next and nothing else is granted.
5. RST asserted during ADD for requester 3 -> no DONE issued; next cycle all outputs are 0 and BUSY=0. After RST is released, REQ=4'b1001 grants requester 0 first.
6. Requester 1 changes A_IN slice and drops REQ the cycle after GNT, with A=5 and B=7 at capture -> SUM=12 with DONE[1], unaffected by the change.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NREQ requesters; GNT at k+1, DONE/result at k+2.
// No backpressure: one operation every 3 cycles; REQ is sampled only in IDLE, so late requesters wait in line.
module adder_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int PTRW  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] A_IN,
  input  logic [NREQ*WIDTH-1:0] B_IN,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic [WIDTH-1:0]      SUM,
  output logic                  COUT,
  output logic                  OVF,
  output logic                  BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [PTRW-1:0]   win_q, win_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;

  logic              found;
  logic [PTRW-1:0]   pick;
  logic [PTRW:0]     cand;
  logic [WIDTH:0]    full;

  // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PTRW+1)'(k);
      if (cand >= (PTRW+1)'(NREQ)) begin
        cand = cand - (PTRW+1)'(NREQ);
      end
      if (!found && REQ[cand[PTRW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PTRW-1:0];
      end
    end
  end

  assign full = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    gnt_d   = '0;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          a_d         = A_IN[pick*WIDTH +: WIDTH];
          b_d         = B_IN[pick*WIDTH +: WIDTH];
          gnt_d[pick] = 1'b1;
          win_d       = pick;
          ptr_d       = (pick == PTRW'(NREQ-1)) ? '0 : pick + PTRW'(1);
          state_d     = S_ADD;
        end
      end
      S_ADD: begin
        sum_d         = full[WIDTH-1:0];
        cout_d        = full[WIDTH];
        ovf_d         = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);
        done_d[win_q] = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign SUM  = sum_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;
  assign BUSY = busy_q;

endmodule
